// File: rtl/mul_issue_ctrl.sv
// Issue/sequencing controller for the 2-cycle EX-stage multiplier: request handshake, operand latch,
// flush draining, hi/lo select and a held response. Optional one-entry product cache under MUL_REUSE_EN.
module mul_issue_ctrl #(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 8
) (
    input  logic              mul_clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [31:0]       req_src1,
    input  logic [31:0]       req_src2,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              mul,
    output logic              mul_signed,
    output logic [31:0]       mul_x,
    output logic [31:0]       mul_y,
    input  logic [63:0]       mul_result,
    input  logic              mul_complete,
    output logic              err_timeout,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_x;
    logic [31:0]       r_y;
    logic [31:0]       r_data;
    logic              r_signed;
    logic              r_hi_sel;
    logic [TAG_W-1:0]  r_tag;
    logic [7:0]        r_cnt;
    logic              r_err;
    logic              w_accept;
    logic              w_capture;
    logic              w_hit;
    logic [31:0]       w_hit_data;
    logic              w_req_signed;
    logic              w_req_hi;
    logic              w_in_mul;
    logic              w_cnt_clr;

    // Both ports use valid/ready: a transfer happens on a clock edge where valid and ready are both
    // high; flush suppresses every transfer in its cycle, including a response the consumer takes.
    assign req_ready    = ~flush & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & resp_ready));
    assign w_accept     = req_valid & req_ready;
    assign w_req_signed = (req_op != 2'b10);
    assign w_req_hi     = (req_op == 2'b01) || (req_op == 2'b10);
    assign w_in_mul     = (r_state == ST_BUSY) || (r_state == ST_DRAIN);
    assign w_cnt_clr    = ((w_next == ST_BUSY) || (w_next == ST_DRAIN)) && (w_next != r_state);

    assign resp_valid  = (r_state == ST_DONE);
    assign resp_data   = r_data;
    assign resp_tag    = r_tag;
    assign mul         = w_in_mul;
    assign mul_signed  = r_signed;
    assign mul_x       = r_x;
    assign mul_y       = r_y;
    assign err_timeout = r_err;
    assign dbg_state   = r_state;

`ifdef MUL_REUSE_EN
    logic [31:0] r_c_x;
    logic [31:0] r_c_y;
    logic        r_c_s;
    logic [63:0] r_c_p;
    logic        r_c_vld;

    assign w_hit      = r_c_vld && (r_c_x == req_src1) && (r_c_y == req_src2) && (r_c_s == w_req_signed);
    assign w_hit_data = w_req_hi ? r_c_p[63:32] : r_c_p[31:0];

    always_ff @(posedge mul_clk) begin
        if (reset) begin
            r_c_x   <= '0;
            r_c_y   <= '0;
            r_c_s   <= 1'b0;
            r_c_p   <= '0;
            r_c_vld <= 1'b0;
        end else if (w_capture) begin
            r_c_x   <= r_x;
            r_c_y   <= r_y;
            r_c_s   <= r_signed;
            r_c_p   <= mul_result;
            r_c_vld <= 1'b1;
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = '0;
`endif

    always_ff @(posedge mul_clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // A flushed BUSY keeps mul high in DRAIN until the multiplier's counter wraps.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = w_hit ? ST_DONE : ST_BUSY;
            end
            ST_BUSY: begin
                if (flush) begin
                    w_next = mul_complete ? ST_IDLE : ST_DRAIN;
                end else if (mul_complete) begin
                    w_next    = ST_DONE;
                    w_capture = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (mul_complete) w_next = ST_IDLE;
            end
            ST_DONE: begin
                if (flush)           w_next = ST_IDLE;
                else if (resp_ready) w_next = w_accept ? (w_hit ? ST_DONE : ST_BUSY) : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge mul_clk) begin
        if (reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_signed <= 1'b0;
            r_hi_sel <= 1'b0;
            r_tag    <= '0;
            r_data   <= '0;
        end else begin
            if (w_accept) begin
                r_x      <= req_src1;
                r_y      <= req_src2;
                r_signed <= w_req_signed;
                r_hi_sel <= w_req_hi;
                r_tag    <= req_tag;
                if (w_hit) r_data <= w_hit_data;
            end
            if (w_capture) r_data <= r_hi_sel ? mul_result[63:32] : mul_result[31:0];
        end
    end

    // Counter saturates at its last value; the error flag is sticky until reset.
    always_ff @(posedge mul_clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_cnt_clr)                         r_cnt <= '0;
            else if (w_in_mul && r_cnt != TO_LAST) r_cnt <= r_cnt + 8'd1;
            if (w_in_mul && r_cnt == TO_LAST)      r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: stub 2-cycle multiplier, scoreboard fed at accept and drained by a
// negedge monitor, directed latency/flush/reset/timeout cases, then randomized traffic.
module tb_mul_issue_ctrl;

    localparam int TAG_W   = 5;
    localparam int TIMEOUT = 8;
`ifdef MUL_REUSE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 3;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_op = 2'b00;
    logic [31:0]       req_src1 = '0;
    logic [31:0]       req_src2 = '0;
    logic [TAG_W-1:0]  req_tag = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [31:0]       resp_data;
    logic [TAG_W-1:0]  resp_tag;
    logic              mul;
    logic              mul_signed;
    logic [31:0]       mul_x;
    logic [31:0]       mul_y;
    logic [63:0]       mul_result;
    logic              mul_complete;
    logic              err_timeout;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_resp   = 0;

    logic [TAG_W+31:0] exp_q[$];
    logic [TAG_W+31:0] exp_word;
    logic [TAG_W+31:0] hold_word;
    logic              stall_prev = 1'b0;

    always #5 clk = ~clk;

    mul_issue_ctrl #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .mul_clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag),
        .mul(mul), .mul_signed(mul_signed), .mul_x(mul_x), .mul_y(mul_y),
        .mul_result(mul_result), .mul_complete(mul_complete),
        .err_timeout(err_timeout), .dbg_state(dbg_state)
    );

    // Stub multiplier: two-phase internal counter, product of the presented operands.
    logic        stub_phase = 1'b0;
    logic        stub_stall = 1'b0;
    logic [63:0] stub_x;
    logic [63:0] stub_y;
    assign stub_x       = mul_signed ? {{32{mul_x[31]}}, mul_x} : {32'd0, mul_x};
    assign stub_y       = mul_signed ? {{32{mul_y[31]}}, mul_y} : {32'd0, mul_y};
    assign mul_result   = stub_x * stub_y;
    assign mul_complete = mul & stub_phase & ~stub_stall;

    always @(posedge clk) begin
        if (reset)                   stub_phase <= 1'b0;
        else if (mul && !stub_stall) stub_phase <= ~stub_phase;
    end

    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        if (op == 2'b10) begin
            p = {32'd0, a} * {32'd0, b};
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = 64'(sa * sb);
        end
        return (op == 2'b01 || op == 2'b10) ? p[63:32] : p[31:0];
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 64'(resp_valid), 64'd1);
                check("hold_tag_data", 64'({resp_tag, resp_data}), 64'(hold_word));
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (resp_valid && resp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL resp_unexpected: got tag 0x%0h data 0x%0h, required no response",
                                 resp_tag, resp_data);
                    end else begin
                        exp_word = exp_q.pop_front();
                        check("resp_tag_data", 64'({resp_tag, resp_data}), 64'(exp_word));
                        n_resp++;
                    end
                end
                if (req_valid && req_ready)
                    exp_q.push_back({req_tag, ref_mul(req_op, req_src1, req_src2)});
            end
            stall_prev = resp_valid && !resp_ready && !flush;
            hold_word  = {resp_tag, resp_data};
        end
    end

    task automatic set_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [TAG_W-1:0] tag);
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        req_tag   = tag;
        req_valid = 1'b1;
    endtask

    // Called one step after a rising edge with the DUT idle; returns after the response handshake.
    task automatic directed_op(input string name, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [TAG_W-1:0] tag, input int lat);
        set_req(op, a, b, tag);
        resp_ready = 1'b1;
        #1;
        check({name, "_req_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            check($sformatf("%s_mul_c%0d", name, c), 64'(mul), 64'(c < lat));
            if (c < lat) check($sformatf("%s_signed_c%0d", name, c), 64'(mul_signed), 64'(op != 2'b10));
            check($sformatf("%s_resp_valid_c%0d", name, c), 64'(resp_valid), 64'(c == lat));
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_resp(input string name, input int max_cyc);
        int n;
        n = 0;
        while (!resp_valid && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_resp_seen"}, 64'(resp_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_mul", 64'(mul), 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        check("rst_data", 64'(resp_data), 64'd0);
        check("rst_tag", 64'(resp_tag), 64'd0);
        check("rst_x_y", 64'({mul_x, mul_y}), 64'd0);
        @(posedge clk); #1;

        directed_op("mulw", 2'b00, 32'h0000_0003, 32'hFFFF_FFFF, 5'h11, 3);
        directed_op("mulhw", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'h02, 3);
        directed_op("mulhwu", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h1F, 3);

        // Response backpressure then same-cycle release and accept.
        resp_ready = 1'b0;
        set_req(2'b00, 32'h0000_1234, 32'h0000_0100, 5'h05);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp("stall", 6);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_valid_%0d", i), 64'(resp_valid), 64'd1);
            check($sformatf("stall_req_ready_%0d", i), 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        set_req(2'b01, 32'hDEAD_BEEF, 32'h0001_2345, 5'h06);
        resp_ready = 1'b1;
        #1;
        check("release_req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b_mul", 64'(mul), 64'd1);
        wait_resp("b2b", 6);
        @(posedge clk); #1;

        // Flush in the completion cycle.
        set_req(2'b00, 32'd5, 32'd5, 5'h07);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        #1;
        check("flush_c2_mul", 64'(mul), 64'd1);
        check("flush_c2_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("flush_c2_after_valid", 64'(resp_valid), 64'd0);
        check("flush_c2_after_mul", 64'(mul), 64'd0);
        check("flush_c2_after_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;

        // Flush in the first BUSY cycle: drain.
        set_req(2'b00, 32'd11, 32'd13, 5'h08);
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("drain_mul", 64'(mul), 64'd1);
        check("drain_req_ready", 64'(req_ready), 64'd0);
        check("drain_resp_valid", 64'(resp_valid), 64'd0);
        @(posedge clk); #1;
        check("drain_done_mul", 64'(mul), 64'd0);
        check("drain_done_valid", 64'(resp_valid), 64'd0);
        check("drain_done_ready", 64'(req_ready), 64'd1);
        directed_op("after_drain", 2'b00, 32'd7, 32'd6, 5'h09, 3);

        // Product reuse: repeat unsigned op, then same operands signed.
        directed_op("reuse_first", 2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 5'h0A, 3);
        directed_op("reuse_again", 2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 5'h0B, HIT_LAT);
        directed_op("reuse_signed", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'h0C, 3);

        // Reset mid-op.
        set_req(2'b00, 32'd9, 32'd9, 5'h0D);
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("midrst_req_ready", 64'(req_ready), 64'd1);
        check("midrst_valid", 64'(resp_valid), 64'd0);
        check("midrst_mul", 64'(mul), 64'd0);
        check("midrst_regs", 64'({resp_tag, resp_data}), 64'd0);
        check("midrst_x_y", 64'({mul_x, mul_y}), 64'd0);
        @(posedge clk); #1;
        directed_op("after_reset", 2'b00, 32'd2, 32'd3, 5'h0E, 3);

        // Timeout with a multiplier that never completes.
        stub_stall = 1'b1;
        set_req(2'b00, 32'd4, 32'd4, 5'h0F);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= TIMEOUT + 1; c++) begin
            check($sformatf("to_mul_c%0d", c), 64'(mul), 64'd1);
            if (c <= TIMEOUT - 1) check($sformatf("to_err_low_c%0d", c), 64'(err_timeout), 64'd0);
            if (c == TIMEOUT + 1) check("to_err_set", 64'(err_timeout), 64'd1);
            @(posedge clk); #1;
        end
        check("to_err_sticky", 64'(err_timeout), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        stub_stall = 1'b0;
        check("to_err_cleared", 64'(err_timeout), 64'd0);

        // Randomized traffic with backpressure and occasional flushes.
        for (int cyc = 0; cyc < 800; cyc++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_op    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                req_src1 = rand_word();
                req_src2 = rand_word();
            end
            req_tag    = TAG_W'($urandom);
            resp_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 19) == 0);
            @(posedge clk); #1;
        end
        req_valid  = 1'b0;
        flush      = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || resp_valid); i++) begin
            @(posedge clk); #1;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("resp_count_ok", 64'(n_resp > 40), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
